// File: rtl/clock_controller.sv
// Clock-enable controller: free-run / single-step / halt CPU clocking from an async divided tick.
// Optional step-button debouncer enabled by defining CLOCK_CONTROLLER_DEBOUNCE_EN.
module clock_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        run_mode,
  input  logic        step_btn,
  input  logic        halt,
  output logic        clk_en,
  output logic        halted,
  output logic        step_pending,
  output logic [15:0] en_count
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STEP_ARM = 2'd2,
    HALTED   = 2'd3
  } state_e;

  if (DEBOUNCE_CYCLES == 0) begin : g_cfg_check
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  state_e             state_q, state_d;
  logic               tick_s1_q, tick_s2_q, tick_prev_q;
  logic               run_s1_q, run_s2_q;
  logic               btn_s1_q, btn_s2_q, btn_prev_q;
  logic               btn_level;
  logic               tick_rise;
  logic               step_press;
  logic               clk_en_d;
  logic               clk_en_q, halted_q, step_pending_q;
  logic [CNT_W-1:0]   en_count_q;

  // Two-flop synchronizers plus previous-value flops for edge detection
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      tick_s1_q   <= 1'b0;
      tick_s2_q   <= 1'b0;
      tick_prev_q <= 1'b0;
      run_s1_q    <= 1'b0;
      run_s2_q    <= 1'b0;
      btn_s1_q    <= 1'b0;
      btn_s2_q    <= 1'b0;
      btn_prev_q  <= 1'b0;
    end else begin
      tick_s1_q   <= tick_in;
      tick_s2_q   <= tick_s1_q;
      tick_prev_q <= tick_s2_q;
      run_s1_q    <= run_mode;
      run_s2_q    <= run_s1_q;
      btn_s1_q    <= step_btn;
      btn_s2_q    <= btn_s1_q;
      btn_prev_q  <= btn_level;
    end
  end

`ifdef CLOCK_CONTROLLER_DEBOUNCE_EN
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            btn_level_q, btn_level_d;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES straight cycles
  always_comb begin
    db_cnt_d    = '0;
    btn_level_d = btn_level_q;
    if (btn_s2_q != btn_level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_level_d = btn_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      db_cnt_q    <= '0;
      btn_level_q <= 1'b0;
    end else begin
      db_cnt_q    <= db_cnt_d;
      btn_level_q <= btn_level_d;
    end
  end

  assign btn_level = btn_level_q;
`else
  assign btn_level = btn_s2_q;
`endif

  assign tick_rise  = tick_s2_q & ~tick_prev_q;
  assign step_press = btn_level & ~btn_prev_q;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: halt overrides everything; HALTED is left only through reset
  always_comb begin
    state_d = state_q;
    if (halt) begin
      state_d = HALTED;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (run_s2_q) begin
            state_d = RUN;
          end else if (step_press) begin
            state_d = STEP_ARM;
          end
        end
        RUN: begin
          if (!run_s2_q) begin
            state_d = IDLE;
          end
        end
        STEP_ARM: begin
          if (run_s2_q) begin
            state_d = RUN;
          end else if (tick_rise) begin
            state_d = IDLE;
          end
        end
        HALTED: state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Enable pulse: suppressed on mode-change cycles and whenever halt is requested
  always_comb begin
    clk_en_d = 1'b0;
    if (!halt) begin
      unique case (state_q)
        RUN:      clk_en_d = run_s2_q & tick_rise;
        STEP_ARM: clk_en_d = ~run_s2_q & tick_rise;
        default:  clk_en_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      clk_en_q       <= 1'b0;
      halted_q       <= 1'b0;
      step_pending_q <= 1'b0;
      en_count_q     <= '0;
    end else begin
      clk_en_q       <= clk_en_d;
      halted_q       <= (state_d == HALTED);
      step_pending_q <= (state_d == STEP_ARM);
      if (clk_en_d) begin
        en_count_q <= en_count_q + CNT_W'(1);
      end
    end
  end

  assign clk_en       = clk_en_q;
  assign halted       = halted_q;
  assign step_pending = step_pending_q;
  assign en_count     = en_count_q;

endmodule

// File: tb/tb_clock_controller.sv
// Directed self-checking bench for clock_controller (debounce depth 8 when the debouncer is built in).
module tb_clock_controller;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        tick_in;
  logic        run_mode;
  logic        step_btn;
  logic        halt;
  logic        clk_en;
  logic        halted;
  logic        step_pending;
  logic [15:0] en_count;

  int errors = 0;
  int checks = 0;
  int pulse_total = 0;

  clock_controller #(.DEBOUNCE_CYCLES(8)) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .tick_in      (tick_in),
    .run_mode     (run_mode),
    .step_btn     (step_btn),
    .halt         (halt),
    .clk_en       (clk_en),
    .halted       (halted),
    .step_pending (step_pending),
    .en_count     (en_count)
  );

  always #5 clk_in = ~clk_in;

  // Running total of enable pulses, sampled just after each rising edge
  always @(posedge clk_in) begin
    #1;
    if (clk_en === 1'b1) pulse_total++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_reset;
    reset    = 1'b0;
    tick_in  = 1'b0;
    run_mode = 1'b0;
    step_btn = 1'b0;
    halt     = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    tick_in  = 1'b0;
    run_mode = 1'b0;
    step_btn = 1'b0;
    halt     = 1'b0;
    step(2);
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en: got %0b expected 0", clk_en); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b expected 0", halted); end
    checks++; if (step_pending !== 1'b0) begin errors++; $display("FAIL reset_step_pending: got %0b expected 0", step_pending); end
    checks++; if (en_count !== 16'h0000) begin errors++; $display("FAIL reset_en_count: got %0h expected 0", en_count); end
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_free_run;
    logic hist [0:209];
    logic exp_en;
    int   base;
    do_reset();
    run_mode = 1'b1;
    step(4);
    base = pulse_total;
    for (int i = 0; i < 210; i++) begin
      if (i >= 4) begin
        exp_en = hist[i-3] & ~hist[i-4];
        checks++;
        if (clk_en !== exp_en) begin
          errors++;
          $display("FAIL free_run_clk_en cycle %0d: got %0b expected %0b", i, clk_en, exp_en);
        end
      end
      hist[i] = (i < 200) ? (((i / 10) % 2) == 1) : 1'b0;
      tick_in = hist[i];
      step(1);
    end
    checks++; if (pulse_total - base != 10) begin errors++; $display("FAIL free_run_pulses: got %0d expected 10", pulse_total - base); end
    checks++; if (en_count !== 16'd10) begin errors++; $display("FAIL free_run_en_count: got %0d expected 10", en_count); end
  endtask

  task automatic test_single_step;
    int base;
    do_reset();
    base = pulse_total;
    step_btn = 1'b1; step(3);
    step_btn = 1'b0; step(3);
`ifdef CLOCK_CONTROLLER_DEBOUNCE_EN
    checks++; if (step_pending !== 1'b0) begin errors++; $display("FAIL step_bounce_rejected: got %0b expected 0", step_pending); end
`endif
    step_btn = 1'b1; step(20);
    checks++; if (step_pending !== 1'b1) begin errors++; $display("FAIL step_armed: got %0b expected 1", step_pending); end
    checks++; if (en_count !== 16'd0) begin errors++; $display("FAIL step_no_early_en: got %0d expected 0", en_count); end
    step_btn = 1'b0; step(12);
    checks++; if (step_pending !== 1'b1) begin errors++; $display("FAIL step_still_armed: got %0b expected 1", step_pending); end
    tick_in = 1'b1; step(2);
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL step_latency_early: got %0b expected 0", clk_en); end
    step(1);
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL step_pulse: got %0b expected 1", clk_en); end
    checks++; if (step_pending !== 1'b0) begin errors++; $display("FAIL step_back_idle: got %0b expected 0", step_pending); end
    checks++; if (en_count !== 16'd1) begin errors++; $display("FAIL step_en_count: got %0d expected 1", en_count); end
    step(1);
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL step_pulse_width: got %0b expected 0", clk_en); end
    tick_in = 1'b0; step(4);
    tick_in = 1'b1; step(6);
    checks++; if (pulse_total - base != 1) begin errors++; $display("FAIL step_single_pulse: got %0d expected 1", pulse_total - base); end
    checks++; if (en_count !== 16'd1) begin errors++; $display("FAIL step_final_count: got %0d expected 1", en_count); end
    tick_in = 1'b0;
  endtask

  task automatic test_double_press;
    int base;
    do_reset();
    base = pulse_total;
    step_btn = 1'b1; step(16);
    step_btn = 1'b0; step(16);
    checks++; if (step_pending !== 1'b1) begin errors++; $display("FAIL dbl_first_press: got %0b expected 1", step_pending); end
    step_btn = 1'b1; step(16);
    step_btn = 1'b0; step(16);
    checks++; if (step_pending !== 1'b1) begin errors++; $display("FAIL dbl_still_armed: got %0b expected 1", step_pending); end
    checks++; if (pulse_total - base != 0) begin errors++; $display("FAIL dbl_no_pulse_yet: got %0d expected 0", pulse_total - base); end
    tick_in = 1'b1; step(6);
    checks++; if (pulse_total - base != 1) begin errors++; $display("FAIL dbl_one_pulse: got %0d expected 1", pulse_total - base); end
    checks++; if (step_pending !== 1'b0) begin errors++; $display("FAIL dbl_idle: got %0b expected 0", step_pending); end
    tick_in = 1'b0; step(4);
    tick_in = 1'b1; step(6);
    checks++; if (pulse_total - base != 1) begin errors++; $display("FAIL dbl_no_queued_step: got %0d expected 1", pulse_total - base); end
    checks++; if (en_count !== 16'd1) begin errors++; $display("FAIL dbl_en_count: got %0d expected 1", en_count); end
    tick_in = 1'b0;
  endtask

  task automatic test_halt;
    int base;
    do_reset();
    run_mode = 1'b1;
    step(4);
    base = pulse_total;
    tick_in = 1'b1; step(2);
    halt = 1'b1; step(1);
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL halt_blocks_pulse: got %0b expected 0", clk_en); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted: got %0b expected 1", halted); end
    halt = 1'b0;
    tick_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(4);
      tick_in  = 1'b1;
      step_btn = ~step_btn;
      run_mode = (i >= 3);
      step(4);
      tick_in = 1'b0;
    end
    step_btn = 1'b0;
    step(20);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %0b expected 1", halted); end
    checks++; if (pulse_total - base != 0) begin errors++; $display("FAIL halt_no_pulses: got %0d expected 0", pulse_total - base); end
    checks++; if (en_count !== 16'd0) begin errors++; $display("FAIL halt_en_count: got %0d expected 0", en_count); end
    checks++; if (step_pending !== 1'b0) begin errors++; $display("FAIL halt_no_step: got %0b expected 0", step_pending); end
  endtask

  task automatic test_wrap;
    do_reset();
    run_mode = 1'b1;
    step(4);
    force dut.en_count_q = 16'hFFFE;
    step(1);
    release dut.en_count_q;
    step(1);
    tick_in = 1'b1; step(3);
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL wrap_pulse_a: got %0b expected 1", clk_en); end
    checks++; if (en_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: got %0h expected ffff", en_count); end
    tick_in = 1'b0; step(4);
    tick_in = 1'b1; step(3);
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL wrap_pulse_b: got %0b expected 1", clk_en); end
    checks++; if (en_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %0h expected 0", en_count); end
    tick_in = 1'b0; step(2);
  endtask

  task automatic test_reset_mid_step;
    int base;
    do_reset();
    run_mode = 1'b1; step(4);
    tick_in = 1'b1; step(4);
    tick_in = 1'b0;
    run_mode = 1'b0; step(4);
    step_btn = 1'b1; step(16);
    step_btn = 1'b0; step(2);
    checks++; if (step_pending !== 1'b1) begin errors++; $display("FAIL rst_pre_armed: got %0b expected 1", step_pending); end
    checks++; if (en_count !== 16'd1) begin errors++; $display("FAIL rst_pre_count: got %0d expected 1", en_count); end
    tick_in = 1'b1; step(1);
    reset = 1'b0;
    #1;
    checks++; if (step_pending !== 1'b0) begin errors++; $display("FAIL rst_async_step_pending: got %0b expected 0", step_pending); end
    checks++; if (en_count !== 16'd0) begin errors++; $display("FAIL rst_async_en_count: got %0d expected 0", en_count); end
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL rst_async_clk_en: got %0b expected 0", clk_en); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_async_halted: got %0b expected 0", halted); end
    step(3);
    run_mode = 1'b1;
    reset = 1'b1;
    base = pulse_total;
    step(12);
    checks++; if (pulse_total - base != 0) begin errors++; $display("FAIL rst_no_stale_tick: got %0d expected 0", pulse_total - base); end
    checks++; if (step_pending !== 1'b0) begin errors++; $display("FAIL rst_step_discarded: got %0b expected 0", step_pending); end
    tick_in = 1'b0; step(4);
    tick_in = 1'b1; step(3);
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL rst_fresh_edge_pulse: got %0b expected 1", clk_en); end
    checks++; if (en_count !== 16'd1) begin errors++; $display("FAIL rst_fresh_count: got %0d expected 1", en_count); end
    tick_in = 1'b0; step(2);
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_single_step();
    test_double_press();
    test_halt();
    test_wrap();
    test_reset_mid_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
